// File: rtl/rsa_pkg.sv
// Shared widths, state encodings and host command codes for the RSA accelerator.
package rsa_pkg;

    localparam int DW = 1024;          // operand / result width
    localparam int TW = 10;            // exponent bit-length field width, cmd[31:22]
    localparam int CW = $clog2(DW);    // Montgomery iteration counter width

    // Host-visible command FSM; the encoding is mirrored on leds[2:0].
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RX      = 3'd1,
        ST_COMPUTE = 3'd2,
        ST_TX      = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Square-and-multiply sequencing inside COMPUTE.
    typedef enum logic [1:0] {
        EXP_INIT_XT,
        EXP_SQ,
        EXP_MUL,
        EXP_FINAL
    } exp_state_t;

    // Bit-serial Montgomery multiplier sequencing.
    typedef enum logic [1:0] {
        MM_IDLE,
        MM_LOOP,
        MM_SUB
    } mm_state_t;

    localparam logic [3:0] CMD_COMPUTE = 4'h0;
    localparam logic [3:0] CMD_WRITE   = 4'h2;
    localparam logic [3:0] CMD_READ_X  = 4'h1;
    localparam logic [3:0] CMD_READ_E  = 4'h3;
    localparam logic [3:0] CMD_READ_R  = 4'h5;
    localparam logic [3:0] CMD_READ_R2 = 4'h7;
    localparam logic [3:0] CMD_READ_M  = 4'h9;

endpackage

// File: rtl/rsa_ctrl_wrapper_mm.sv
// Bit-serial radix-2 Montgomery multiplier: result = a*b*2^-DW mod m.
// b and m must stay stable from start until done; a is captured at start.
// done pulses for one cycle; result is valid then and held afterwards.
module montgomery_mult
    import rsa_pkg::*;
(
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [DW-1:0] m,
    output logic [DW-1:0] result,
    output logic          done
);

    localparam logic [CW-1:0] LAST_BIT = CW'(DW - 1);

    mm_state_t     state;
    logic [DW+1:0] s;        // partial sum, kept below 2^(DW+1)
    logic [DW-1:0] a_sh;     // multiplier, consumed LSB first
    logic [CW-1:0] cnt;
    logic [DW+1:0] sum_ab;
    logic [DW+1:0] sum_m;
    logic [DW+1:0] diff;

    // One radix-2 step: add b for a set multiplier bit, add m to make the sum even, then halve.
    always_comb begin
        sum_ab = s + (a_sh[0] ? {2'b00, b} : '0);
        sum_m  = sum_ab[0] ? (sum_ab + {2'b00, m}) : sum_ab;
        diff   = s - {2'b00, m};
    end

    // Iterate DW steps, then one conditional subtraction brings the sum below m.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= MM_IDLE;
            s      <= '0;
            a_sh   <= '0;
            cnt    <= '0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                MM_IDLE: begin
                    if (start) begin
                        s     <= '0;
                        a_sh  <= a;
                        cnt   <= '0;
                        state <= MM_LOOP;
                    end
                end
                MM_LOOP: begin
                    s    <= {1'b0, sum_m[DW+1:1]};
                    a_sh <= a_sh >> 1;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        state <= MM_SUB;
                    end
                end
                MM_SUB: begin
                    result <= (s >= {2'b00, m}) ? diff[DW-1:0] : s[DW-1:0];
                    done   <= 1'b1;
                    state  <= MM_IDLE;
                end
                default: state <= MM_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/rsa_ctrl_wrapper.sv
// Host-facing RSA accelerator: operand load, modular exponentiation, result readback.
// Handshakes: an operand is taken in the RX cycle where arm_to_fpga_data_valid is high and
// arm_to_fpga_data_ready pulses once in reply; a result transfers on the first cycle with
// fpga_to_arm_data_valid && fpga_to_arm_data_ready, with data held stable while valid is high.
module rsa_ctrl_wrapper
    import rsa_pkg::*;
(
    input  logic          clk,
    input  logic          resetn,
    input  logic [31:0]   arm_to_fpga_cmd,
    input  logic          arm_to_fpga_cmd_valid,
    output logic          arm_to_fpga_done,
    input  logic          arm_to_fpga_done_read,
    input  logic          arm_to_fpga_data_valid,
    output logic          arm_to_fpga_data_ready,
    input  logic [DW-1:0] arm_to_fpga_data,
    output logic          fpga_to_arm_data_valid,
    input  logic          fpga_to_arm_data_ready,
    output logic [DW-1:0] fpga_to_arm_data,
    output logic [3:0]    leds
);

    state_t        state;
    exp_state_t    exp_state;
    logic [3:0]    rx_code;
    logic [TW-1:0] bit_idx;   // exponent bits still to square over; the 10-bit field caps t at 1023
    logic [DW-1:0] x_reg, e_reg, m_reg, r_reg, r2_reg;
    logic [DW-1:0] xt_reg, result_reg;
    logic [DW-1:0] mm_a, mm_b, mm_res, next_a;
    logic          mm_start, mm_done;

    assign leds             = {1'b0, state};
    assign fpga_to_arm_data = result_reg;

    montgomery_mult u_mm (
        .clk    (clk),
        .resetn (resetn),
        .start  (mm_start),
        .a      (mm_a),
        .b      (mm_b),
        .m      (m_reg),
        .result (mm_res),
        .done   (mm_done)
    );

    // Accumulator entering the next ladder step: R after the Xt conversion, otherwise the last product.
    always_comb next_a = (exp_state == EXP_INIT_XT) ? r_reg : mm_res;

    // Command FSM with the exponent sequencer nested in COMPUTE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state                  <= ST_IDLE;
            exp_state              <= EXP_INIT_XT;
            rx_code                <= '0;
            bit_idx                <= '0;
            x_reg                  <= '0;
            e_reg                  <= '0;
            m_reg                  <= '0;
            r_reg                  <= '0;
            r2_reg                 <= '0;
            xt_reg                 <= '0;
            result_reg             <= '0;
            mm_a                   <= '0;
            mm_b                   <= '0;
            mm_start               <= 1'b0;
            arm_to_fpga_done       <= 1'b0;
            arm_to_fpga_data_ready <= 1'b0;
            fpga_to_arm_data_valid <= 1'b0;
        end else begin
            mm_start               <= 1'b0;
            arm_to_fpga_data_ready <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arm_to_fpga_cmd_valid) begin
                        if (arm_to_fpga_cmd[0]) begin
                            rx_code <= arm_to_fpga_cmd[3:0];
                            case (arm_to_fpga_cmd[3:0])
                                CMD_READ_X, CMD_READ_E, CMD_READ_R,
                                CMD_READ_R2, CMD_READ_M: state <= ST_RX;
                                default: begin
                                    // Unknown load target: acknowledge without touching any operand.
                                    arm_to_fpga_done <= 1'b1;
                                    state            <= ST_DONE;
                                end
                            endcase
                        end else if (arm_to_fpga_cmd[1]) begin
                            fpga_to_arm_data_valid <= 1'b1;
                            state                  <= ST_TX;
                        end else begin
                            mm_a      <= x_reg;
                            mm_b      <= r2_reg;
                            mm_start  <= 1'b1;
                            exp_state <= EXP_INIT_XT;
                            bit_idx   <= arm_to_fpga_cmd[31:22];
                            state     <= ST_COMPUTE;
                        end
                    end
                end
                ST_RX: begin
                    if (arm_to_fpga_data_valid) begin
                        case (rx_code)
                            CMD_READ_X:  x_reg  <= arm_to_fpga_data;
                            CMD_READ_E:  e_reg  <= arm_to_fpga_data;
                            CMD_READ_R:  r_reg  <= arm_to_fpga_data;
                            CMD_READ_R2: r2_reg <= arm_to_fpga_data;
                            CMD_READ_M:  m_reg  <= arm_to_fpga_data;
                            default: ;
                        endcase
                        arm_to_fpga_data_ready <= 1'b1;
                        arm_to_fpga_done       <= 1'b1;
                        state                  <= ST_DONE;
                    end
                end
                ST_COMPUTE: begin
                    if (mm_done) begin
                        if (exp_state == EXP_FINAL) begin
                            result_reg       <= mm_res;
                            arm_to_fpga_done <= 1'b1;
                            state            <= ST_DONE;
                        end else if (exp_state == EXP_SQ && e_reg[bit_idx]) begin
                            mm_a      <= mm_res;
                            mm_b      <= xt_reg;
                            mm_start  <= 1'b1;
                            exp_state <= EXP_MUL;
                        end else begin
                            if (exp_state == EXP_INIT_XT) begin
                                xt_reg <= mm_res;
                            end
                            mm_a     <= next_a;
                            mm_start <= 1'b1;
                            if (bit_idx == '0) begin
                                // Multiplying by plain 1 leaves the Montgomery domain.
                                mm_b      <= DW'(1);
                                exp_state <= EXP_FINAL;
                            end else begin
                                mm_b      <= next_a;
                                bit_idx   <= bit_idx - 1'b1;
                                exp_state <= EXP_SQ;
                            end
                        end
                    end
                end
                ST_TX: begin
                    if (fpga_to_arm_data_ready) begin
                        fpga_to_arm_data_valid <= 1'b0;
                        arm_to_fpga_done       <= 1'b1;
                        state                  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (arm_to_fpga_done_read) begin
                        arm_to_fpga_done <= 1'b0;
                        state            <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_ctrl_wrapper.sv
// Self-checking bench for rsa_ctrl_wrapper: fixed vectors plus random operand sets
// checked against a plain modular-exponentiation model.
module tb_rsa_ctrl_wrapper;
    import rsa_pkg::*;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [31:0]   cmd = '0;
    logic          cmd_valid = 1'b0;
    logic          done;
    logic          done_read = 1'b0;
    logic          data_valid = 1'b0;
    logic          data_ready;
    logic [DW-1:0] data_in = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [3:0]    leds;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW-1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1, "watchdog");
    end

    rsa_ctrl_wrapper dut (
        .clk                    (clk),
        .resetn                 (resetn),
        .arm_to_fpga_cmd        (cmd),
        .arm_to_fpga_cmd_valid  (cmd_valid),
        .arm_to_fpga_done       (done),
        .arm_to_fpga_done_read  (done_read),
        .arm_to_fpga_data_valid (data_valid),
        .arm_to_fpga_data_ready (data_ready),
        .arm_to_fpga_data       (data_in),
        .fpga_to_arm_data_valid (out_valid),
        .fpga_to_arm_data_ready (out_ready),
        .fpga_to_arm_data       (out_data),
        .leds                   (leds)
    );

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (low 128 bits)", tag, obs[127:0], exp_v[127:0]);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] v;
        for (int w = 0; w < DW / 32; w++) v[w*32 +: 32] = $urandom;
        return v;
    endfunction

    // X^E[t-1:0] mod M by ordinary square-and-multiply on double-width products.
    function automatic logic [DW-1:0] model_modexp(input logic [DW-1:0] x, input logic [DW-1:0] e,
                                                   input int t, input logic [DW-1:0] m);
        logic [2*DW-1:0] mm, acc, xx;
        mm  = {{DW{1'b0}}, m};
        acc = {{(2*DW-1){1'b0}}, 1'b1} % mm;
        xx  = {{DW{1'b0}}, x} % mm;
        for (int i = t - 1; i >= 0; i--) begin
            acc = (acc * acc) % mm;
            if (e[i]) acc = (acc * xx) % mm;
        end
        return acc[DW-1:0];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send_cmd(input logic [31:0] c);
        @(negedge clk);
        cmd       = c;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int i = 0;
        while (!done && i < budget) begin
            @(negedge clk);
            i++;
        end
        check({tag, "_done"}, DW'(done), DW'(1));
        done_read = 1'b1;
        @(negedge clk);
        done_read = 1'b0;
        check({tag, "_done_clr"}, DW'(done), DW'(0));
        check({tag, "_idle"}, DW'(leds), DW'(0));
    endtask

    task automatic load(input string tag, input logic [3:0] code, input logic [DW-1:0] val,
                        input int exp_pulses);
        int pulses = 0;
        send_cmd({28'd0, code});
        data_in    = val;
        data_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (data_ready) begin
                pulses++;
                data_valid = 1'b0;
            end
        end
        data_valid = 1'b0;
        check({tag, "_ready_pulses"}, DW'(pulses), DW'(exp_pulses));
        wait_done(tag, 20);
    endtask

    task automatic load_all(input logic [DW-1:0] x, input logic [DW-1:0] e, input logic [DW-1:0] m,
                            input logic [DW-1:0] r, input logic [DW-1:0] r2);
        load("ld_x", CMD_READ_X, x, 1);
        load("ld_e", CMD_READ_E, e, 1);
        load("ld_m", CMD_READ_M, m, 1);
        load("ld_r", CMD_READ_R, r, 1);
        load("ld_r2", CMD_READ_R2, r2, 1);
    endtask

    task automatic compute(input string tag, input logic [TW-1:0] t, input bit poke);
        send_cmd({t, 22'd0});
        check({tag, "_busy"}, DW'(leds), DW'(ST_COMPUTE));
        if (poke) begin
            repeat (50) @(negedge clk);
            send_cmd({28'd0, CMD_WRITE});
            check({tag, "_ignore_write"}, DW'(leds), DW'(ST_COMPUTE));
            check({tag, "_ignore_valid"}, DW'(out_valid), DW'(0));
            send_cmd({28'd0, CMD_READ_X});
            check({tag, "_ignore_rx"}, DW'(leds), DW'(ST_COMPUTE));
        end
        wait_done(tag, (2 + 2 * int'(t)) * (DW + 3) + 100);
    endtask

    task automatic read_result(input string tag, input int stall);
        logic [DW-1:0] got = '0;
        logic [DW-1:0] exp_v;
        int i = 0;
        exp_v = exp_q.pop_front();
        send_cmd({28'd0, CMD_WRITE});
        while (!out_valid && i < 20) begin
            @(negedge clk);
            i++;
        end
        check({tag, "_valid"}, DW'(out_valid), DW'(1));
        if (stall > 0) begin
            repeat (stall) @(negedge clk);
            check({tag, "_stall_valid"}, DW'(out_valid), DW'(1));
            check({tag, "_stall_done"}, DW'(done), DW'(0));
            check({tag, "_stall_data"}, out_data, exp_v);
        end
        out_ready = 1'b1;
        got = out_data;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, DW'(out_valid), DW'(0));
        check({tag, "_data"}, got, exp_v);
        wait_done(tag, 20);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [DW-1:0]   ones;
        logic [DW-1:0]   m, x, e, r, r2;
        logic [2*DW-1:0] wide, mm;
        logic [TW-1:0]   t;

        #25;
        check("rst_done", DW'(done), DW'(0));
        check("rst_ready", DW'(data_ready), DW'(0));
        check("rst_out_valid", DW'(out_valid), DW'(0));
        check("rst_leds", DW'(leds), DW'(0));
        check("rst_data", out_data, '0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("post_rst_leds", DW'(leds), DW'(0));

        // Modulus 2^DW-1 with R=R2=1 makes every Montgomery product an ordinary product.
        ones = '1;
        load_all(DW'(3), DW'(5), ones, DW'(1), DW'(1));
        compute("small", 10'd3, 1'b0);
        exp_q.push_back(DW'(243));
        read_result("small_rd", 20);

        compute("t0", 10'd0, 1'b0);
        exp_q.push_back(DW'(1));
        read_result("t0_rd", 0);

        // Unknown load target must complete without a data_ready pulse.
        load("ld_bad", 4'hB, rand_word(), 0);

        for (int trial = 0; trial < 2; trial++) begin
            m = rand_word();
            m[DW-1] = 1'b1;
            m[0]    = 1'b1;
            mm   = {{DW{1'b0}}, m};
            wide = '0;
            wide[DW] = 1'b1;
            wide = wide % mm;
            r    = wide[DW-1:0];
            wide = ({{DW{1'b0}}, r} * {{DW{1'b0}}, r}) % mm;
            r2   = wide[DW-1:0];
            wide = {{DW{1'b0}}, rand_word()} % mm;
            x    = wide[DW-1:0];
            e    = rand_word();
            t    = TW'($urandom_range(3, 7));
            load_all(x, e, m, r, r2);
            compute("rnd", t, trial == 0);
            exp_q.push_back(model_modexp(x, e, int'(t), m));
            read_result("rnd_rd", trial == 1 ? 5 : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
